// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage: word-addressed PC, IF/ID pipeline register and a
//   two-state RUN/HALT controller. Redirects (branch over jump) always win,
//   flush IF/ID and leave HALT. Fetching at or beyond MEM_DEPTH parks the stage
//   in HALT, where it emits bubbles until the next redirect.
//
//   Optional build macro: FETCH_PERF_CNT_EN adds fetchCount / stallCount
//   performance counters as extra output ports.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  output logic [31:0] pcOut,
  input  logic [31:0] instrIn,
  output logic [31:0] ifidInstr,
  output logic [31:0] ifidPcPlus1,
  output logic        ifidValid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // Widened limit so the compare stays correct for any 32-bit PC value.
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_DEPTH);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_plus1_q, ifid_pc_plus1_d;
  logic        ifid_valid_q, ifid_valid_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus1;
  logic        past_end;
  logic        fetch_fire;
  logic        stall_hit;

  // Redirect decode: branch outranks jump when both are raised together.
  assign redirect        = branchTaken | jump;
  assign redirect_target = branchTaken ? branchTarget : jumpTarget;
  assign pc_plus1        = pc_q + 32'd1;
  assign past_end        = {1'b0, pc_q} >= MEM_LIMIT;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all registers update
    // together from pre-edge values, independent of statement order.
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: any redirect resumes RUN; running off the end halts.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    if (redirect)
      state_d = ST_RUN;
    else if (state_q == ST_RUN && !stall && past_end)
      state_d = ST_HALT;
  end

  // Output / datapath control: choose next PC and what IF/ID captures.
  always_comb begin
    pc_d            = pc_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_plus1_d = ifid_pc_plus1_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_fire      = 1'b0;
    stall_hit       = 1'b0;

    if (redirect) begin
      // Flush: wrong-path instruction in IF/ID becomes a bubble.
      pc_d            = redirect_target;
      ifid_instr_d    = NOP_WORD;
      ifid_pc_plus1_d = 32'd0;
      ifid_valid_d    = 1'b0;
    end else if (state_q == ST_HALT || past_end) begin
      // Halted (stall ignored) or about to halt: PC holds, bubbles flow.
      if (state_q == ST_RUN && stall) begin
        stall_hit = 1'b1;
      end else begin
        ifid_instr_d    = NOP_WORD;
        ifid_pc_plus1_d = 32'd0;
        ifid_valid_d    = 1'b0;
      end
    end else if (stall) begin
      // Hazard hold: PC and IF/ID keep their values.
      stall_hit = 1'b1;
    end else begin
      pc_d            = pc_plus1;
      ifid_instr_d    = instrIn;
      ifid_pc_plus1_d = pc_plus1;
      ifid_valid_d    = 1'b1;
      fetch_fire      = 1'b1;
    end
  end

  assign halted      = (state_q == ST_HALT);
  assign pcOut       = pc_q;
  assign ifidInstr   = ifid_instr_q;
  assign ifidPcPlus1 = ifid_pc_plus1_q;
  assign ifidValid   = ifid_valid_q;

  // PC and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q            <= 32'd0;
      ifid_instr_q    <= NOP_WORD;
      ifid_pc_plus1_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_plus1_q <= ifid_pc_plus1_d;
      ifid_valid_q    <= ifid_valid_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Performance counters: real fetches and RUN-state stall cycles, free-wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (fetch_fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_hit)  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetchCount = fetch_cnt_q;
  assign stallCount = stall_cnt_q;
`else
  // Counter enables have no consumer in this build.
  logic unused_perf;
  assign unused_perf = fetch_fire ^ stall_hit;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed scenarios followed by a randomized phase, all compared against a
//   behavioural model of the fetch rules (PC, IF/ID contents, halt flag and,
//   when FETCH_PERF_CNT_EN is defined, the performance counters).
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic [31:0] pcOut;
  logic [31:0] instrIn;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus1;
  logic        ifidValid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
`endif

  fetch_stage #(
    .MEM_DEPTH (DEPTH),
    .NOP_WORD  (NOP)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .pcOut        (pcOut),
    .instrIn      (instrIn),
    .ifidInstr    (ifidInstr),
    .ifidPcPlus1  (ifidPcPlus1),
    .ifidValid    (ifidValid),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetchCount   (fetchCount),
    .stallCount   (stallCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: combinational read at pcOut.
  logic [31:0] mem [DEPTH];
  always_comb begin
    if (pcOut < DEPTH) instrIn = mem[pcOut[4:0]];
    else               instrIn = 32'hBAD0_0000;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pp1, m_fetch, m_stall;
  logic        m_valid, m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < DEPTH) ? mem[a[4:0]] : 32'hBAD0_0000;
  endfunction

  task automatic bubble();
    m_instr = NOP;
    m_pp1   = 32'd0;
    m_valid = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    if (!reset) begin
      m_pc = 0; m_halt = 0; m_fetch = 0; m_stall = 0;
      bubble();
    end else if (branchTaken || jump) begin
      m_pc   = branchTaken ? branchTarget : jumpTarget;
      m_halt = 0;
      bubble();
    end else if (m_halt) begin
      bubble();
    end else if (stall) begin
      m_stall = m_stall + 1;
    end else if (m_pc >= DEPTH) begin
      m_halt = 1;
      bubble();
    end else begin
      m_instr = mem_word(m_pc);
      m_pc    = m_pc + 1;
      m_pp1   = m_pc;
      m_valid = 1;
      m_fetch = m_fetch + 1;
    end
  endtask

  task automatic check_all();
    check("pcOut",       pcOut,             m_pc);
    check("ifidInstr",   ifidInstr,         m_instr);
    check("ifidPcPlus1", ifidPcPlus1,       m_pp1);
    check("ifidValid",   {31'd0, ifidValid}, {31'd0, m_valid});
    check("halted",      {31'd0, halted},    {31'd0, m_halt});
`ifdef FETCH_PERF_CNT_EN
    check("fetchCount",  fetchCount,        m_fetch);
    check("stallCount",  stallCount,        m_stall);
`endif
  endtask

  // Model update before the edge, compare on the following falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    stall = 0; branchTaken = 0; jump = 0;
    branchTarget = 0; jumpTarget = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

    // Reset with every control input raised: reset must win.
    reset = 0; stall = 1; branchTaken = 1; jump = 1;
    branchTarget = 32'd9; jumpTarget = 32'd9;
    cycle();
    cycle();
    check("rst_pc",    pcOut,     32'd0);
    check("rst_instr", ifidInstr, NOP);

    // Free run from address 0.
    reset = 1; idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      cycle();
      check("seq_pc",   pcOut,       32'(k));
      check("seq_pp1",  ifidPcPlus1, 32'(k));
      check("seq_inst", ifidInstr,   32'(k * 32'h11));
    end
    cycle();
    check("at5_pc", pcOut, 32'd5);

    // Two stall cycles hold everything.
    stall = 1;
    cycle();
    cycle();
    check("stall_pc",  pcOut,       32'd5);
    check("stall_pp1", ifidPcPlus1, 32'd5);
    stall = 0;
    cycle();
    check("rel_pc",  pcOut,       32'd6);
    check("rel_pp1", ifidPcPlus1, 32'd6);
    cycle();

    // Branch, jump and stall together: branch wins, IF/ID flushed.
    branchTaken = 1; branchTarget = 32'd2; jump = 1; jumpTarget = 32'd9; stall = 1;
    cycle();
    check("redir_pc",    pcOut,              32'd2);
    check("redir_valid", {31'd0, ifidValid}, 32'd0);
    check("redir_instr", ifidInstr,          NOP);
    idle_inputs();

    // Run off the end of memory into HALT.
    for (int n = 0; n < 64 && !m_halt; n++) cycle();
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_pc",   pcOut,           32'd32);
    stall = 1;
    cycle();
    check("halt_hold_pc", pcOut, 32'd32);
    stall = 0; jump = 1; jumpTarget = 32'd4;
    cycle();
    check("unhalt_pc",   pcOut,           32'd4);
    check("unhalt_flag", {31'd0, halted}, 32'd0);
    idle_inputs();

    // Randomized traffic including out-of-range targets and reset pulses.
    for (int n = 0; n < 400; n++) begin
      stall        = ($urandom_range(0, 99) < 30);
      branchTaken  = ($urandom_range(0, 99) < 5);
      jump         = ($urandom_range(0, 99) < 5);
      branchTarget = 32'($urandom_range(0, 40));
      jumpTarget   = 32'($urandom_range(0, 40));
      reset        = !($urandom_range(0, 99) < 2);
      cycle();
    end
    reset = 1; idle_inputs();

    // Redirect past the end, halt on the next free cycle, then reset mid-HALT.
    jump = 1; jumpTarget = 32'd35;
    cycle();
    idle_inputs();
    cycle();
    check("far_halt", {31'd0, halted}, 32'd1);
    stall = 1; reset = 0;
    cycle();
    check("hrst_pc",    pcOut,              32'd0);
    check("hrst_halt",  {31'd0, halted},    32'd0);
    check("hrst_valid", {31'd0, ifidValid}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("hrst_fcnt", fetchCount, 32'd0);
    check("hrst_scnt", stallCount, 32'd0);
`endif
    reset = 1; stall = 0;
    cycle();
    check("post_rst_pp1", ifidPcPlus1, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
